cart_bus_ctrl: RTL and testbench

//  Cartridge-side responder for the internal ROM request port (rom_addr/rom_rd/rom_data/rom_bsy)

---
 rtl/cart_bus_ctrl_pkg.sv | 34 +++
 rtl/cart_bus_ctrl_if.sv | 29 ++
 rtl/cart_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_cart_bus_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_ctrl_pkg.sv
// Shared types and constants for the cartridge bus controller.
package cart_bus_ctrl_pkg;

  // Bus cycle phases; the encoding is fixed so external debug taps stay stable.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    MD_RD = 1'b0,
    MD_WR = 1'b1
  } mode_t;

  // External RAM window that asserts /CS.
  localparam logic [15:0] CS_LO = 16'hA000;
  localparam logic [15:0] CS_HI = 16'hDFFF;

  // Default phase lengths in clk_8m cycles.
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 1;

  // Phase counter width; every phase length must lie in 1..8.
  localparam int CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic cs_hit(input logic [15:0] a);
    return (a >= CS_LO) && (a <= CS_HI);
  endfunction

endpackage

// File: rtl/cart_bus_ctrl_if.sv
// ROM request port plus cartridge pin bundle.
// master = requester and cart environment, slave = the bus controller.
interface cart_bus_ctrl_if;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic        rom_wr;
  logic [7:0]  rom_wdata;
  logic [7:0]  rom_data;
  logic        rom_bsy;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_in;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;

  modport master (
    output rom_addr, rom_rd, rom_wr, rom_wdata, cart_d_in,
    input  rom_data, rom_bsy, cart_a, cart_d_out, cart_d_oe,
           cart_rd_n, cart_wr_n, cart_cs_n
  );

  modport slave (
    input  rom_addr, rom_rd, rom_wr, rom_wdata, cart_d_in,
    output rom_data, rom_bsy, cart_a, cart_d_out, cart_d_oe,
           cart_rd_n, cart_wr_n, cart_cs_n
  );
endinterface

// File: rtl/cart_bus_ctrl.sv
// Cartridge bus controller: turns single-cycle rd/wr requests into timed
// setup/strobe/hold cart bus cycles. Every output is a flop.
module cart_bus_ctrl
  import cart_bus_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input logic             clk_8m,
  input logic             rst,
  cart_bus_ctrl_if.slave  bus
);

  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t      r_state,      w_nxt_state;
  cnt_t        r_cnt,        w_nxt_cnt;
  mode_t       r_mode,       w_nxt_mode;
  logic [7:0]  r_rom_data,   w_nxt_rom_data;
  logic        r_rom_bsy,    w_nxt_rom_bsy;
  logic [15:0] r_cart_a,     w_nxt_cart_a;
  logic [7:0]  r_cart_d_out, w_nxt_cart_d_out;
  logic        r_cart_d_oe,  w_nxt_cart_d_oe;
  logic        r_cart_rd_n,  w_nxt_cart_rd_n;
  logic        r_cart_wr_n,  w_nxt_cart_wr_n;
  logic        r_cart_cs_n,  w_nxt_cart_cs_n;

  // Next-state and next-output decode; requests are only seen in IDLE.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_mode       = r_mode;
    w_nxt_rom_data   = r_rom_data;
    w_nxt_rom_bsy    = r_rom_bsy;
    w_nxt_cart_a     = r_cart_a;
    w_nxt_cart_d_out = r_cart_d_out;
    w_nxt_cart_d_oe  = r_cart_d_oe;
    w_nxt_cart_rd_n  = r_cart_rd_n;
    w_nxt_cart_wr_n  = r_cart_wr_n;
    w_nxt_cart_cs_n  = r_cart_cs_n;
    case (r_state)
      ST_IDLE: begin
        if (bus.rom_rd || bus.rom_wr) begin
          w_nxt_state     = ST_SETUP;
          w_nxt_cnt       = cnt_t'(SETUP_CYC - 1);
          w_nxt_rom_bsy   = 1'b1;
          w_nxt_cart_a    = bus.rom_addr;
          w_nxt_cart_cs_n = !cs_hit(bus.rom_addr);
          // Read has priority; a simultaneous write is dropped.
          if (bus.rom_rd) begin
            w_nxt_mode = MD_RD;
          end else begin
            w_nxt_mode       = MD_WR;
            w_nxt_cart_d_out = bus.rom_wdata;
            w_nxt_cart_d_oe  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_STROBE;
          w_nxt_cnt   = cnt_t'(STROBE_CYC - 1);
          if (r_mode == MD_RD) w_nxt_cart_rd_n = 1'b0;
          else                 w_nxt_cart_wr_n = 1'b0;
        end else begin
          w_nxt_cnt = r_cnt - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_nxt_state     = ST_HOLD;
          w_nxt_cnt       = cnt_t'(HOLD_CYC - 1);
          w_nxt_cart_rd_n = 1'b1;
          w_nxt_cart_wr_n = 1'b1;
          // Cart data has been settling for the whole strobe, so the
          // asynchronous bus is captured directly on the release edge.
          if (r_mode == MD_RD) w_nxt_rom_data = bus.cart_d_in;
        end else begin
          w_nxt_cnt = r_cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_nxt_state     = ST_IDLE;
          w_nxt_rom_bsy   = 1'b0;
          w_nxt_cart_d_oe = 1'b0;
          w_nxt_cart_cs_n = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt - CNT_ONE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mode       <= MD_RD;
      r_rom_data   <= 8'hFF;
      r_rom_bsy    <= 1'b0;
      r_cart_a     <= 16'h0000;
      r_cart_d_out <= 8'h00;
      r_cart_d_oe  <= 1'b0;
      r_cart_rd_n  <= 1'b1;
      r_cart_wr_n  <= 1'b1;
      r_cart_cs_n  <= 1'b1;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_mode       <= w_nxt_mode;
      r_rom_data   <= w_nxt_rom_data;
      r_rom_bsy    <= w_nxt_rom_bsy;
      r_cart_a     <= w_nxt_cart_a;
      r_cart_d_out <= w_nxt_cart_d_out;
      r_cart_d_oe  <= w_nxt_cart_d_oe;
      r_cart_rd_n  <= w_nxt_cart_rd_n;
      r_cart_wr_n  <= w_nxt_cart_wr_n;
      r_cart_cs_n  <= w_nxt_cart_cs_n;
    end
  end

  assign bus.rom_data   = r_rom_data;
  assign bus.rom_bsy    = r_rom_bsy;
  assign bus.cart_a     = r_cart_a;
  assign bus.cart_d_out = r_cart_d_out;
  assign bus.cart_d_oe  = r_cart_d_oe;
  assign bus.cart_rd_n  = r_cart_rd_n;
  assign bus.cart_wr_n  = r_cart_wr_n;
  assign bus.cart_cs_n  = r_cart_cs_n;

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Directed bench for cart_bus_ctrl with a combinational cart ROM model.
`timescale 1ns/1ps
module tb_cart_bus_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cart_bus_ctrl_if b();

  cart_bus_ctrl dut (
    .clk_8m (clk),
    .rst    (rst),
    .bus    (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cart ROM model: byte = low address byte + 0xCA, driven only while /RD low.
  function automatic logic [7:0] cart_byte(input logic [15:0] a);
    return a[7:0] + 8'hCA;
  endfunction

  assign b.cart_d_in = b.cart_rd_n ? 8'h00 : cart_byte(b.cart_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and watch the busy window. Sample k is taken just
  // after the k-th edge following the request edge. inj_at >= 0 pulses a
  // second read (address inj_a) that should be ignored.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [7:0] wd,
                         input int inj_at, input logic [15:0] inj_a,
                         output int nb, output int nrd, output int nwr,
                         output int ncs, output int noe, output int nviol);
    nb = 0; nrd = 0; nwr = 0; ncs = 0; noe = 0; nviol = 0;
    b.rom_addr  = a;
    b.rom_wdata = wd;
    b.rom_rd    = rd;
    b.rom_wr    = wr;
    tick();
    b.rom_rd = 1'b0;
    b.rom_wr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!b.rom_bsy) break;
      nb++;
      if (!b.cart_rd_n) nrd++;
      if (!b.cart_wr_n) nwr++;
      if (!b.cart_cs_n) ncs++;
      if (b.cart_d_oe)  noe++;
      if (!b.cart_rd_n && !b.cart_wr_n) nviol++;
      if (b.cart_d_oe && !b.cart_rd_n)  nviol++;
      if (b.cart_d_oe && b.cart_d_out !== wd) nviol++;
      if (b.cart_a !== a) nviol++;
      if (k == inj_at) begin
        b.rom_rd   = 1'b1;
        b.rom_addr = inj_a;
      end
      tick();
      b.rom_rd = 1'b0;
    end
    chk({tag, "_done"}, {31'd0, b.rom_bsy}, 32'd0);
  endtask

  int nb, nrd, nwr, ncs, noe, nviol;
  int seq_bad;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    b.rom_addr = 16'h0000;
    b.rom_rd = 1'b0;
    b.rom_wr = 1'b0;
    b.rom_wdata = 8'h00;
    repeat (3) tick();

    // Reset state
    chk("rst_data", {24'd0, b.rom_data}, 32'hFF);
    chk("rst_bsy",  {31'd0, b.rom_bsy}, 32'd0);
    chk("rst_a",    {16'd0, b.cart_a}, 32'h0000);
    chk("rst_dout", {24'd0, b.cart_d_out}, 32'h00);
    chk("rst_oe",   {31'd0, b.cart_d_oe}, 32'd0);
    chk("rst_rdn",  {31'd0, b.cart_rd_n}, 32'd1);
    chk("rst_wrn",  {31'd0, b.cart_wr_n}, 32'd1);
    chk("rst_csn",  {31'd0, b.cart_cs_n}, 32'd1);
    rst = 1'b0;
    tick();

    // 1: single read at 0x0104, cart drives 0xCE
    run_txn("t1", 1'b1, 1'b0, 16'h0104, 8'h00, -1, 16'h0, nb, nrd, nwr, ncs, noe, nviol);
    chk("t1_bsy_cyc", nb, 7);
    chk("t1_rd_cyc", nrd, 4);
    chk("t1_wr_cyc", nwr, 0);
    chk("t1_cs_cyc", ncs, 0);
    chk("t1_oe_cyc", noe, 0);
    chk("t1_viol", nviol, 0);
    chk("t1_data", {24'd0, b.rom_data}, 32'hCE);

    // 2: logo fetch 0x0104..0x0133, each issued on the first !bsy sample
    seq_bad = 0;
    for (int i = 0; i < 48; i++) begin
      logic [15:0] a;
      a = 16'h0104 + 16'(i);
      run_txn("t2", 1'b1, 1'b0, a, 8'h00, -1, 16'h0, nb, nrd, nwr, ncs, noe, nviol);
      chk("t2_data", {24'd0, b.rom_data}, {24'd0, cart_byte(a)});
      chk("t2_addr", {16'd0, b.cart_a}, {16'd0, a});
      if (nb != 7 || nrd != 4 || nwr != 0 || nviol != 0) seq_bad++;
    end
    chk("t2_timing", seq_bad, 0);

    // 3: MBC write 0x01 to 0x2000; read data must be left alone (last was 0xFD)
    run_txn("t3", 1'b0, 1'b1, 16'h2000, 8'h01, -1, 16'h0, nb, nrd, nwr, ncs, noe, nviol);
    chk("t3_bsy_cyc", nb, 7);
    chk("t3_wr_cyc", nwr, 4);
    chk("t3_rd_cyc", nrd, 0);
    chk("t3_oe_cyc", noe, 7);
    chk("t3_viol", nviol, 0);
    chk("t3_oe_off", {31'd0, b.cart_d_oe}, 32'd0);
    chk("t3_data", {24'd0, b.rom_data}, 32'hFD);

    // 4: read in RAM window with a second rd 3 cycles in (ignored)
    run_txn("t4", 1'b1, 1'b0, 16'hA000, 8'h00, 2, 16'h0300, nb, nrd, nwr, ncs, noe, nviol);
    chk("t4_bsy_cyc", nb, 7);
    chk("t4_cs_cyc", ncs, 7);
    chk("t4_viol", nviol, 0);
    chk("t4_data", {24'd0, b.rom_data}, 32'hCA);
    chk("t4_csn_off", {31'd0, b.cart_cs_n}, 32'd1);
    tick();
    chk("t4_no_queue", {31'd0, b.rom_bsy}, 32'd0);
    chk("t4_addr", {16'd0, b.cart_a}, 32'hA000);

    // 5: rd and wr together, read wins
    run_txn("t5", 1'b1, 1'b1, 16'h0150, 8'h77, -1, 16'h0, nb, nrd, nwr, ncs, noe, nviol);
    chk("t5_wr_cyc", nwr, 0);
    chk("t5_rd_cyc", nrd, 4);
    chk("t5_oe_cyc", noe, 0);
    chk("t5_data", {24'd0, b.rom_data}, 32'h1A);

    // request on the IDLE-return edge is dropped
    run_txn("t5b", 1'b1, 1'b0, 16'h0160, 8'h00, 6, 16'h0400, nb, nrd, nwr, ncs, noe, nviol);
    chk("t5b_bsy_cyc", nb, 7);
    tick();
    chk("t5b_no_accept", {31'd0, b.rom_bsy}, 32'd0);
    chk("t5b_addr", {16'd0, b.cart_a}, 32'h0160);

    // 6: reset during STROBE, then a clean read
    b.rom_addr = 16'hB170;
    b.rom_rd = 1'b1;
    tick();
    b.rom_rd = 1'b0;
    repeat (3) tick();
    chk("t6_in_strobe", {31'd0, b.cart_rd_n}, 32'd0);
    rst = 1'b1;
    tick();
    chk("t6_rdn", {31'd0, b.cart_rd_n}, 32'd1);
    chk("t6_bsy", {31'd0, b.rom_bsy}, 32'd0);
    chk("t6_data", {24'd0, b.rom_data}, 32'hFF);
    chk("t6_csn", {31'd0, b.cart_cs_n}, 32'd1);
    chk("t6_a", {16'd0, b.cart_a}, 32'h0000);
    rst = 1'b0;
    tick();
    run_txn("t6r", 1'b1, 1'b0, 16'h0180, 8'h00, -1, 16'h0, nb, nrd, nwr, ncs, noe, nviol);
    chk("t6r_bsy_cyc", nb, 7);
    chk("t6r_rd_cyc", nrd, 4);
    chk("t6r_data", {24'd0, b.rom_data}, 32'h4A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
